// File: rtl/axil_pulse_gen_if.sv
// Purpose : bundles the four config words and the status outputs of axil_pulse_gen.
// Latency : none, this is wiring only.
// Backpres: none, the config words are levels and the status outputs are levels or strobes.
// Ports   : master drives ctrl/period/width/count (and trig_in with AXIL_PULSE_GEN_TRIG_EN),
//           and samples pulse_out/busy/done/pulse_cnt. slave is the generator side.
interface axil_pulse_gen_if #(
  parameter int DW = 32
);
  logic [DW-1:0] ctrl_reg;
  logic [DW-1:0] period_reg;
  logic [DW-1:0] width_reg;
  logic [DW-1:0] count_reg;
`ifdef AXIL_PULSE_GEN_TRIG_EN
  logic          trig_in;
`endif
  logic          pulse_out;
  logic          busy;
  logic          done;
  logic [DW-1:0] pulse_cnt;

  modport master (
`ifdef AXIL_PULSE_GEN_TRIG_EN
    output trig_in,
`endif
    output ctrl_reg, period_reg, width_reg, count_reg,
    input  pulse_out, busy, done, pulse_cnt
  );

  modport slave (
`ifdef AXIL_PULSE_GEN_TRIG_EN
    input  trig_in,
`endif
    input  ctrl_reg, period_reg, width_reg, count_reg,
    output pulse_out, busy, done, pulse_cnt
  );
endinterface

// File: rtl/axil_pulse_gen.sv
// Purpose : programmable pulse-train burst generator driven by four AXI-lite config words.
// Latency : a start edge in cycle N gives busy and the first high output cycle at N+1.
// Backpres: none; starts seen while busy are dropped, and config is latched at start.
// Ports   : S_AXI_ACLK clock, S_AXI_ARESET sync active-high reset, bus (slave modport):
//           ctrl_reg [0]=start edge [1]=abort [2]=continuous [3]=trig_mode,
//           period_reg/width_reg/count_reg, pulse_out, busy, done strobe, pulse_cnt.
// Option  : define AXIL_PULSE_GEN_TRIG_EN to add trig_in and the WAIT_TRIG state.
module axil_pulse_gen #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int TRIG_SYNC_STAGES = 2
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESET,
  axil_pulse_gen_if.slave   bus
);
  localparam int DW = C_AXI_DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN       = 2'd1,
    S_WAIT_TRIG = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_ph, w_ph_nxt;
  logic [DW-1:0] r_cnt, w_cnt_nxt;
  logic [DW-1:0] r_period_l, w_period_l_nxt;
  logic [DW-1:0] r_width_l, w_width_l_nxt;
  logic [DW-1:0] r_count_l, w_count_l_nxt;
  logic          r_cont_l, w_cont_l_nxt;
  logic          r_pulse, w_pulse_nxt;
  logic          r_done, w_done_nxt;
  logic          r_ctrl0_q;

  logic          w_start_edge;
  logic          w_abort;
  logic          w_start_ok;
  logic          w_trig_mode;
  logic          w_trig_edge;
  logic [DW-1:0] w_period_m1;
  logic [DW-1:0] w_width_clamp;
  logic [DW-1:0] w_ph_inc;
  logic [DW-1:0] w_cnt_inc;
  logic          w_wrap;

`ifdef AXIL_PULSE_GEN_TRIG_EN
  // Plain shift synchroniser; the edge is taken after the last stage.
  logic [TRIG_SYNC_STAGES-1:0] r_trig_sync;
  logic                        r_trig_prev;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_trig_sync <= '0;
      r_trig_prev <= 1'b0;
    end else begin
      r_trig_sync[0] <= bus.trig_in;
      for (int i = 1; i < TRIG_SYNC_STAGES; i++) begin
        r_trig_sync[i] <= r_trig_sync[i-1];
      end
      r_trig_prev <= r_trig_sync[TRIG_SYNC_STAGES-1];
    end
  end

  assign w_trig_edge = r_trig_sync[TRIG_SYNC_STAGES-1] & ~r_trig_prev;
  assign w_trig_mode = bus.ctrl_reg[3];

  logic w_unused_ok;
  assign w_unused_ok = ^bus.ctrl_reg[DW-1:4];
`else
  // No trigger path: trig_mode is ignored and the synchroniser depth has no use.
  assign w_trig_edge = 1'b0;
  assign w_trig_mode = 1'b0;

  logic                        w_unused_ok;
  logic [TRIG_SYNC_STAGES-1:0] w_unused_sync;
  assign w_unused_sync = '0;
  assign w_unused_ok   = ^{bus.ctrl_reg[DW-1:3], w_unused_sync};
`endif

  assign w_start_edge  = bus.ctrl_reg[0] & ~r_ctrl0_q;
  assign w_abort       = bus.ctrl_reg[1];
  assign w_start_ok    = w_start_edge && (bus.period_reg != '0) &&
                         ((bus.count_reg != '0) || bus.ctrl_reg[2]);
  // Clamp keeps at least one low cycle per period; period==1 yields width 0.
  assign w_period_m1   = bus.period_reg - DW'(1);
  assign w_width_clamp = (bus.width_reg > w_period_m1) ? w_period_m1 : bus.width_reg;
  assign w_ph_inc      = r_ph + DW'(1);
  assign w_cnt_inc     = r_cnt + DW'(1);
  assign w_wrap        = (r_ph == (r_period_l - DW'(1)));

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state    <= S_IDLE;
      r_ph       <= '0;
      r_cnt      <= '0;
      r_period_l <= '0;
      r_width_l  <= '0;
      r_count_l  <= '0;
      r_cont_l   <= 1'b0;
      r_pulse    <= 1'b0;
      r_done     <= 1'b0;
      r_ctrl0_q  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ph       <= w_ph_nxt;
      r_cnt      <= w_cnt_nxt;
      r_period_l <= w_period_l_nxt;
      r_width_l  <= w_width_l_nxt;
      r_count_l  <= w_count_l_nxt;
      r_cont_l   <= w_cont_l_nxt;
      r_pulse    <= w_pulse_nxt;
      r_done     <= w_done_nxt;
      r_ctrl0_q  <= bus.ctrl_reg[0];
    end
  end

  // The output register is loaded with the level for the *next* phase, so
  // pulse_out lines up with ph in the same cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_ph_nxt       = r_ph;
    w_cnt_nxt      = r_cnt;
    w_period_l_nxt = r_period_l;
    w_width_l_nxt  = r_width_l;
    w_count_l_nxt  = r_count_l;
    w_cont_l_nxt   = r_cont_l;
    w_pulse_nxt    = 1'b0;
    w_done_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!w_abort && w_start_ok) begin
          w_period_l_nxt = bus.period_reg;
          w_width_l_nxt  = w_width_clamp;
          w_count_l_nxt  = bus.count_reg;
          w_cont_l_nxt   = bus.ctrl_reg[2];
          w_ph_nxt       = '0;
          w_cnt_nxt      = '0;
          if (w_trig_mode) begin
            w_state_nxt = S_WAIT_TRIG;
          end else begin
            w_state_nxt = S_RUN;
            w_pulse_nxt = (w_width_clamp != '0);
          end
        end
      end

      S_RUN: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_wrap) begin
          w_ph_nxt  = '0;
          w_cnt_nxt = w_cnt_inc;
          if (!r_cont_l && (w_cnt_inc == r_count_l)) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_pulse_nxt = (r_width_l != '0);
          end
        end else begin
          w_ph_nxt    = w_ph_inc;
          w_pulse_nxt = (w_ph_inc < r_width_l);
        end
      end

      S_WAIT_TRIG: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_trig_edge) begin
          w_state_nxt = S_RUN;
          w_ph_nxt    = '0;
          w_pulse_nxt = (r_width_l != '0);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.pulse_out = r_pulse;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.pulse_cnt = r_cnt;

endmodule

// File: tb/tb_axil_pulse_gen.sv
// Purpose : directed scoreboard bench for axil_pulse_gen.
// Latency : expectations are keyed to the cycle count after each start edge.
// Backpres: n/a; the monitor pops every expectation whose cycle has arrived.
module tb_axil_pulse_gen;
  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  axil_pulse_gen_if #(.DW(32)) bus ();

  axil_pulse_gen #(
    .C_AXI_DATA_WIDTH(32),
    .TRIG_SYNC_STAGES(2)
  ) dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          k;
    int          tid;
    logic        p;
    logic        b;
    logic        d;
    bit          chk_cnt;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  task automatic expect_at(input int c, input int k, input int tid, input logic p,
                           input logic b, input logic d, input bit cc, input logic [31:0] cnt);
    exp_t e;
    e.cyc = c; e.k = k; e.tid = tid; e.p = p; e.b = b; e.d = d; e.chk_cnt = cc; e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  // Finite burst seen from the start cycle n: high while (k-1)%P < W, busy for P*C
  // cycles, done one cycle later, pulse_cnt = completed periods.
  task automatic push_burst(input int n, input int p, input int w, input int c,
                            input int kmax, input int tid);
    int last;
    last = p * c;
    for (int k = 1; k <= kmax; k++) begin
      logic pe, be, de;
      bit   cc;
      int   ce;
      pe = (k <= last) && (((k - 1) % p) < w);
      be = (k <= last);
      de = (k == last + 1);
      cc = ((k - 1) % p == 0) || (k > last);
      ce = (k > last) ? c : (k - 1) / p;
      expect_at(n + k, k, tid, pe, be, de, cc, 32'(ce));
    end
  endtask

  // Monitor: compares every expectation due this cycle against the DUT outputs.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        failures++;
        $display("FAIL t%0d k=%0d stale expectation at cyc %0d (due %0d)", e.tid, e.k, cyc, e.cyc);
      end else if ({bus.pulse_out, bus.busy, bus.done} !== {e.p, e.b, e.d} ||
                   (e.chk_cnt && bus.pulse_cnt !== e.cnt)) begin
        failures++;
        $display("FAIL t%0d k=%0d pulse/busy/done/cnt got=%b%b%b/%0d exp=%b%b%b/%0d%s",
                 e.tid, e.k, bus.pulse_out, bus.busy, bus.done, bus.pulse_cnt,
                 e.p, e.b, e.d, e.cnt, e.chk_cnt ? "" : "(cnt not checked)");
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int p, input int w, input int c);
    bus.period_reg = 32'(p);
    bus.width_reg  = 32'(w);
    bus.count_reg  = 32'(c);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.ctrl_reg = '0;
    cfg(0, 0, 0);
`ifdef AXIL_PULSE_GEN_TRIG_EN
    bus.trig_in = 1'b0;
`endif
    tick(3);
    // t0: reset state
    expect_at(cyc, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    rst = 1'b0;
    tick(2);

    // t1: P=10 W=3 C=4; a restart and a period change mid-burst must do nothing
    cfg(10, 3, 4);
    bus.ctrl_reg = 32'h1; n = cyc;
    push_burst(n, 10, 3, 4, 42, 1);
    tick(1); bus.ctrl_reg = 32'h0;
    tick(4); bus.ctrl_reg = 32'h1; bus.period_reg = 32'd3;
    tick(1); bus.ctrl_reg = 32'h0;
    tick(40);

    // t2: width 9 clamps to 4 at period 5
    cfg(5, 9, 2);
    bus.ctrl_reg = 32'h1; n = cyc;
    push_burst(n, 5, 4, 2, 12, 2);
    tick(1); bus.ctrl_reg = 32'h0;
    tick(14);

    // t3: period 0, count 0 non-continuous, abort together with start: all ignored
    cfg(0, 3, 3);
    bus.ctrl_reg = 32'h1; n = cyc;
    for (int k = 1; k <= 3; k++) expect_at(n + k, k, 3, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2);
    tick(1); bus.ctrl_reg = 32'h0; tick(4);
    cfg(5, 3, 0);
    bus.ctrl_reg = 32'h1; n = cyc;
    for (int k = 1; k <= 3; k++) expect_at(n + k, k, 31, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2);
    tick(1); bus.ctrl_reg = 32'h0; tick(4);
    cfg(5, 3, 2);
    bus.ctrl_reg = 32'h3; n = cyc;
    for (int k = 1; k <= 3; k++) expect_at(n + k, k, 32, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2);
    tick(1); bus.ctrl_reg = 32'h0; tick(4);

    // t4: abort at N+25 of a long burst, then a count=1 burst completes
    cfg(10, 3, 100);
    bus.ctrl_reg = 32'h1; n = cyc;
    push_burst(n, 10, 3, 100, 25, 4);
    for (int k = 26; k <= 29; k++) expect_at(n + k, k, 4, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2);
    tick(1); bus.ctrl_reg = 32'h0;
    tick(24); bus.ctrl_reg = 32'h2;
    tick(1); bus.ctrl_reg = 32'h0;
    tick(5);
    cfg(10, 3, 1);
    bus.ctrl_reg = 32'h1; n = cyc;
    push_burst(n, 10, 3, 1, 12, 41);
    tick(1); bus.ctrl_reg = 32'h0;
    tick(13);

    // t5: abort coincides with the finishing wrap -> no done, count held at 0
    cfg(4, 2, 1);
    bus.ctrl_reg = 32'h1; n = cyc;
    push_burst(n, 4, 2, 1, 4, 5);
    expect_at(n + 5, 5, 5, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    tick(1); bus.ctrl_reg = 32'h0;
    tick(3); bus.ctrl_reg = 32'h2;
    tick(1); bus.ctrl_reg = 32'h0;
    tick(3);

    // t6: reset mid-burst returns everything to reset values
    cfg(10, 3, 5);
    bus.ctrl_reg = 32'h1; n = cyc;
    push_burst(n, 10, 3, 5, 15, 6);
    expect_at(n + 16, 16, 6, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    expect_at(n + 17, 17, 6, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    tick(1); bus.ctrl_reg = 32'h0;
    tick(14); rst = 1'b1;
    tick(1); rst = 1'b0;
    tick(4);

    // t7: continuous P=4 W=1; period change mid-run ignored; 400 cycles -> 100 periods
    cfg(4, 1, 0);
    bus.ctrl_reg = 32'h5; n = cyc;
    for (int k = 1; k <= 401; k++)
      expect_at(n + k, k, 7, ((k - 1) % 4) == 0, 1'b1, 1'b0,
                (k == 201) || (k == 401), 32'((k - 1) / 4));
    expect_at(n + 402, 402, 7, 1'b0, 1'b0, 1'b0, 1'b1, 32'd100);
    tick(1); bus.ctrl_reg = 32'h4;
    tick(49); bus.period_reg = 32'd7;
    tick(351); bus.ctrl_reg = 32'h6;
    tick(1); bus.ctrl_reg = 32'h0;
    tick(4);

`ifdef AXIL_PULSE_GEN_TRIG_EN
    // t8: trig_mode waits with busy high; trig raised in N+5 reaches RUN at N+8
    cfg(4, 1, 2);
    bus.ctrl_reg = 32'h9; n = cyc;
    for (int k = 1; k <= 7; k++) expect_at(n + k, k, 8, 1'b0, 1'b1, 1'b0, k == 1, 32'd0);
    push_burst(n + 7, 4, 1, 2, 9, 8);
    tick(1); bus.ctrl_reg = 32'h8;
    tick(4); bus.trig_in = 1'b1;
    tick(5); bus.trig_in = 1'b0;
    tick(8);
    // t9: abort while waiting for the trigger
    bus.ctrl_reg = 32'h9; n = cyc;
    for (int k = 1; k <= 3; k++) expect_at(n + k, k, 9, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    expect_at(n + 4, 4, 9, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    tick(1); bus.ctrl_reg = 32'h8;
    tick(2); bus.ctrl_reg = 32'h2;
    tick(1); bus.ctrl_reg = 32'h0;
    tick(4);
`endif

    tick(3);
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain left=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
